// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// default sizes, FSM state encoding and the config-length legality check.
package seq_det_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;
  localparam int LEN_W       = $clog2(MAX_LEN_DEF + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A pattern length is usable only when it selects 1..max_len bits
  function automatic logic cfg_len_legal(input int unsigned len, input int unsigned max_len);
    return (len != 32'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Configuration ready/valid port of the pattern detector; master offers a
// config, slave accepts it and reports an illegal length.
interface seq_det_if
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) ();

  localparam int LEN_BITS = $clog2(MAX_LEN + 1);

  logic                cfg_valid;
  logic                cfg_ready;
  logic [MAX_LEN-1:0]  cfg_pattern;
  logic [LEN_BITS-1:0] cfg_len;
  logic                cfg_overlap;
  logic [CNT_W-1:0]    cfg_target;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/seq_det_window.sv
// Serial history window: shifts qualified bits in, counts fresh bits up to the
// pattern length and flags a hit on the updated window.
module seq_det_window
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN  = MAX_LEN_DEF,
  localparam int LEN_BITS = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                x,
  input  logic                overlap,
  input  logic [MAX_LEN-1:0]  pattern,
  input  logic [LEN_BITS-1:0] len,
  output logic                hit
);

  // Only MAX_LEN-1 old bits are kept; the incoming bit completes the window
  logic [MAX_LEN-2:0]  history_r;
  logic [MAX_LEN-1:0]  history_next_s;
  logic [MAX_LEN-1:0]  mask_s;
  logic [LEN_BITS-1:0] bit_cnt_r;
  logic [LEN_BITS-1:0] bit_cnt_next_s;

  // Next window contents, saturating bit count and length mask
  always_comb begin
    history_next_s = {history_r, x};
    mask_s         = {MAX_LEN{1'b0}};
    if (bit_cnt_r < len) begin
      bit_cnt_next_s = bit_cnt_r + LEN_BITS'(1);
    end else begin
      bit_cnt_next_s = bit_cnt_r;
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (LEN_BITS'(i) < len);
    end
  end

  assign hit = en && (bit_cnt_next_s >= len) &&
               (((history_next_s ^ pattern) & mask_s) == {MAX_LEN{1'b0}});

  // History and fresh-bit counter; non-overlap mode restarts the count on a hit
  always_ff @(posedge clk) begin
    if (rst) begin
      history_r <= {(MAX_LEN-1){1'b0}};
      bit_cnt_r <= {LEN_BITS{1'b0}};
    end else if (clr) begin
      history_r <= {(MAX_LEN-1){1'b0}};
      bit_cnt_r <= {LEN_BITS{1'b0}};
    end else if (en) begin
      history_r <= history_next_s[MAX_LEN-2:0];
      if (hit && !overlap) begin
        bit_cnt_r <= {LEN_BITS{1'b0}};
      end else begin
        bit_cnt_r <= bit_cnt_next_s;
      end
    end else begin
      history_r <= history_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern-detector controller: config handshake, IDLE/RUN/DONE
// control, saturating match counter and registered Moore outputs.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter  int MAX_LEN  = MAX_LEN_DEF,
  parameter  int CNT_W    = CNT_W_DEF,
  localparam int LEN_BITS = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_if.slave         cfg,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic             x_valid,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  state_e              state_r;
  state_e              state_next_s;
  logic                cfg_loaded_r;
  logic [MAX_LEN-1:0]  pattern_r;
  logic [LEN_BITS-1:0] len_r;
  logic                overlap_r;
  logic [CNT_W-1:0]    target_r;

  logic                cfg_fire_s;
  logic                cfg_legal_s;
  logic                cfg_take_s;
  logic                loaded_eff_s;
  logic                win_clr_s;
  logic                win_en_s;
  logic                hit_s;
  logic                y_next_s;
  logic [CNT_W-1:0]    count_next_s;

  logic                cfg_ready_r;
  logic                cfg_err_r;
  logic                y_r;
  logic                busy_r;
  logic                done_r;
  logic [CNT_W-1:0]    count_r;

  assign cfg_fire_s   = cfg.cfg_valid && cfg_ready_r;
  assign cfg_legal_s  = cfg_len_legal(32'(cfg.cfg_len), 32'(MAX_LEN));
  assign cfg_take_s   = cfg_fire_s && cfg_legal_s;
  // A config accepted on the same edge as start counts as loaded
  assign loaded_eff_s = cfg_loaded_r || cfg_take_s;

  seq_det_window #(.MAX_LEN(MAX_LEN)) u_window (
    .clk     (clk),
    .rst     (rst),
    .clr     (win_clr_s),
    .en      (win_en_s),
    .x       (x),
    .overlap (overlap_r),
    .pattern (pattern_r),
    .len     (len_r),
    .hit     (hit_s)
  );

  // Next state, window control, match pulse and counter update
  always_comb begin
    state_next_s = state_r;
    win_clr_s    = 1'b0;
    win_en_s     = 1'b0;
    y_next_s     = 1'b0;
    count_next_s = count_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else if (start && loaded_eff_s) begin
          state_next_s = ST_RUN;
          win_clr_s    = 1'b1;
          count_next_s = {CNT_W{1'b0}};
        end else begin
          state_next_s = state_r;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next_s = ST_IDLE;
        end else begin
          win_en_s = x_valid;
          if (hit_s) begin
            y_next_s = 1'b1;
            if (count_r == {CNT_W{1'b1}}) begin
              count_next_s = count_r;
            end else begin
              count_next_s = count_r + CNT_W'(1);
            end
            if ((target_r != {CNT_W{1'b0}}) && (count_next_s == target_r)) begin
              state_next_s = ST_DONE;
            end else begin
              state_next_s = ST_RUN;
            end
          end else begin
            state_next_s = ST_RUN;
          end
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Stored configuration; illegal lengths leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_loaded_r <= 1'b0;
      pattern_r    <= {MAX_LEN{1'b0}};
      len_r        <= {LEN_BITS{1'b0}};
      overlap_r    <= 1'b0;
      target_r     <= {CNT_W{1'b0}};
    end else if (cfg_take_s) begin
      cfg_loaded_r <= 1'b1;
      pattern_r    <= cfg.cfg_pattern;
      len_r        <= cfg.cfg_len;
      overlap_r    <= cfg.cfg_overlap;
      target_r     <= cfg.cfg_target;
    end else begin
      cfg_loaded_r <= cfg_loaded_r;
      pattern_r    <= pattern_r;
      len_r        <= len_r;
      overlap_r    <= overlap_r;
      target_r     <= target_r;
    end
  end

  // Output registers, decoded from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ready_r <= 1'b1;
      cfg_err_r   <= 1'b0;
      y_r         <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      count_r     <= {CNT_W{1'b0}};
    end else begin
      cfg_ready_r <= (state_next_s != ST_RUN);
      cfg_err_r   <= cfg_fire_s && !cfg_legal_s;
      y_r         <= y_next_s;
      busy_r      <= (state_next_s == ST_RUN);
      done_r      <= (state_next_s == ST_DONE);
      count_r     <= count_next_s;
    end
  end

  assign cfg.cfg_ready = cfg_ready_r;
  assign cfg.cfg_err   = cfg_err_r;
  assign y             = y_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign match_count   = count_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl: expected per-bit outputs
// are queued as bits are driven and compared once the DUT has clocked them.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       x;
  logic       x_valid;
  logic       y;
  logic       busy;
  logic       done;
  logic [7:0] match_count;

  seq_det_if #(.MAX_LEN(8), .CNT_W(8)) cfg_if ();

  seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cfg_if),
    .start       (start),
    .abort       (abort),
    .x           (x),
    .x_valid     (x_valid),
    .y           (y),
    .busy        (busy),
    .done        (done),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       y;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic ey, input logic eb, input logic ed, input logic [7:0] ec);
    exp_t e;
    e.tag  = tag;
    e.y    = ey;
    e.busy = eb;
    e.done = ed;
    e.cnt  = ec;
    sb_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, ".y"},    32'(y),           32'(e.y));
      chk({e.tag, ".busy"}, 32'(busy),        32'(e.busy));
      chk({e.tag, ".done"}, 32'(done),        32'(e.done));
      chk({e.tag, ".cnt"},  32'(match_count), 32'(e.cnt));
    end
  endtask

  // One serial cycle: drive bit, queue expectation, clock, compare
  task automatic bit_step(input logic b, input logic v, input logic ab, input logic ey,
                          input logic eb, input logic ed, input logic [7:0] ec, input string tag);
    x       = b;
    x_valid = v;
    abort   = ab;
    push_exp(tag, ey, eb, ed, ec);
    tick();
    pop_check();
    x_valid = 1'b0;
    abort   = 1'b0;
  endtask

  // Bits and y mask are MSB-first; done_at is the 1-based bit where done rises (0 = never)
  task automatic stream(input logic [15:0] bits, input logic [15:0] ymask, input int n,
                        input logic [7:0] cnt0, input int done_at, input string tag);
    logic [7:0] ec;
    logic       ed;
    ec = cnt0;
    for (int i = 0; i < n; i++) begin
      if (ymask[n-1-i]) ec = ec + 8'd1;
      ed = (done_at != 0) && (i + 1 >= done_at);
      bit_step(bits[n-1-i], 1'b1, 1'b0, ymask[n-1-i], !ed, ed, ec, $sformatf("%s.b%0d", tag, i + 1));
    end
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [7:0] t,
                          input logic st, input logic eerr, input string tag);
    cfg_if.cfg_valid   = 1'b1;
    cfg_if.cfg_pattern = p;
    cfg_if.cfg_len     = l;
    cfg_if.cfg_overlap = ov;
    cfg_if.cfg_target  = t;
    start              = st;
    tick();
    cfg_if.cfg_valid   = 1'b0;
    start              = 1'b0;
    chk({tag, ".cfg_err"}, 32'(cfg_if.cfg_err), 32'(eerr));
  endtask

  task automatic do_abort(input logic [7:0] ec, input string tag);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk({tag, ".busy"},  32'(busy),        32'd0);
    chk({tag, ".done"},  32'(done),        32'd0);
    chk({tag, ".y"},     32'(y),           32'd0);
    chk({tag, ".cnt"},   32'(match_count), 32'(ec));
    chk({tag, ".ready"}, 32'(cfg_if.cfg_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".ready"}, 32'(cfg_if.cfg_ready), 32'd1);
    chk({tag, ".err"},   32'(cfg_if.cfg_err),   32'd0);
    chk({tag, ".y"},     32'(y),                32'd0);
    chk({tag, ".busy"},  32'(busy),             32'd0);
    chk({tag, ".done"},  32'(done),             32'd0);
    chk({tag, ".cnt"},   32'(match_count),      32'd0);
  endtask

  initial begin
    rst                = 1'b1;
    start              = 1'b0;
    abort              = 1'b0;
    x                  = 1'b0;
    x_valid            = 1'b0;
    cfg_if.cfg_valid   = 1'b0;
    cfg_if.cfg_pattern = 8'h00;
    cfg_if.cfg_len     = 4'd0;
    cfg_if.cfg_overlap = 1'b0;
    cfg_if.cfg_target  = 8'd0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // 1: overlapping 1011, no target
    load_cfg(8'h0B, 4'd4, 1'b1, 8'd0, 1'b0, 1'b0, "t1");
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1.start.busy",  32'(busy), 32'd1);
    chk("t1.start.ready", 32'(cfg_if.cfg_ready), 32'd0);
    stream(16'b1011011, 16'b0001001, 7, 8'd0, 0, "t1");
    do_abort(8'd2, "t1.abort");

    // 2: non-overlapping, config and start in the same cycle
    load_cfg(8'h0B, 4'd4, 1'b0, 8'd0, 1'b1, 1'b0, "t2");
    chk("t2.start.busy", 32'(busy), 32'd1);
    chk("t2.start.cnt",  32'(match_count), 32'd0);
    stream(16'b1011011, 16'b0001000, 7, 8'd0, 0, "t2");
    do_abort(8'd1, "t2.abort");

    // 3: target of 2, further bits ignored in DONE, then rerun from DONE
    load_cfg(8'h0B, 4'd4, 1'b1, 8'd2, 1'b1, 1'b0, "t3");
    stream(16'b10110111011, 16'b00010010000, 11, 8'd0, 7, "t3");
    tick();
    chk("t3.hold.done",  32'(done),             32'd1);
    chk("t3.hold.ready", 32'(cfg_if.cfg_ready), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3.rerun.busy", 32'(busy),        32'd1);
    chk("t3.rerun.done", 32'(done),        32'd0);
    chk("t3.rerun.cnt",  32'(match_count), 32'd0);
    do_abort(8'd0, "t3.abort");

    // 4: illegal lengths after reset; start must be ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_cfg(8'h0B, 4'd0, 1'b1, 8'd0, 1'b0, 1'b1, "t4.len0");
    tick();
    chk("t4.len0.pulse_end", 32'(cfg_if.cfg_err), 32'd0);
    load_cfg(8'h0B, 4'd9, 1'b1, 8'd0, 1'b0, 1'b1, "t4.len9");
    tick();
    chk("t4.len9.pulse_end", 32'(cfg_if.cfg_err), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4.start.busy", 32'(busy), 32'd0);
    tick();
    chk("t4.idle.busy",  32'(busy), 32'd0);

    // 5: x_valid gap inside a pattern, then abort on a final matching bit
    load_cfg(8'h0B, 4'd4, 1'b1, 8'd0, 1'b1, 1'b0, "t5");
    chk("t5.start.busy", 32'(busy), 32'd1);
    stream(16'b101, 16'b000, 3, 8'd0, 0, "t5.pre");
    for (int i = 0; i < 3; i++) begin
      bit_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, $sformatf("t5.gap%0d", i));
    end
    bit_step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, "t5.b4");
    stream(16'b01, 16'b00, 2, 8'd1, 0, "t5.post");
    bit_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, "t5.abort_hit");
    tick();
    chk("t5.after.y", 32'(y), 32'd0);

    // 6: reset during RUN after a match loses the config
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6.start.busy", 32'(busy), 32'd1);
    stream(16'b1011, 16'b0001, 4, 8'd0, 0, "t6");
    rst = 1'b1;
    tick();
    check_reset_outputs("t6.rst");
    rst   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6.nocfg.busy", 32'(busy), 32'd0);
    load_cfg(8'h0B, 4'd4, 1'b1, 8'd0, 1'b1, 1'b0, "t6.reload");
    chk("t6.reload.busy", 32'(busy), 32'd1);
    do_abort(8'd0, "t6.abort");

    // Counter saturation with target 0: single-bit pattern hits every cycle
    load_cfg(8'h01, 4'd1, 1'b1, 8'd0, 1'b1, 1'b0, "sat");
    x       = 1'b1;
    x_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      tick();
    end
    chk("sat.cnt",  32'(match_count), 32'd255);
    chk("sat.busy", 32'(busy),        32'd1);
    chk("sat.done", 32'(done),        32'd0);
    chk("sat.y",    32'(y),           32'd1);
    x_valid = 1'b0;
    do_abort(8'd255, "sat.abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
